// File: rtl/stat_access_arbiter_pkg.sv
// Shared encodings for the pet-stat access arbiter: grant ids, FSM states, stat indices.
// Latency: none (constants and one pure helper function).
// Backpressure: not applicable.
package stat_access_arbiter_pkg;

  localparam int SEL_W = 3;

  // Owner of the register-file port, as reported on grant_id
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CMD  = 2'd1,
    GNT_TICK = 2'd2,
    GNT_RND  = 2'd3
  } gnt_e;

  // Read-modify-write sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Register-file slot of each pet stat
  localparam logic [SEL_W-1:0] STAT_HUNGER    = 3'd0;
  localparam logic [SEL_W-1:0] STAT_HAPPINESS = 3'd1;
  localparam logic [SEL_W-1:0] STAT_HEALTH    = 3'd2;
  localparam logic [SEL_W-1:0] STAT_HYGIENE   = 3'd3;
  localparam logic [SEL_W-1:0] STAT_ENERGY    = 3'd4;
  localparam logic [SEL_W-1:0] STAT_SOCIAL    = 3'd5;

  // Round-robin order is cmd -> tick -> rnd -> cmd; returns the requester after the last winner
  function automatic gnt_e rr_next(input gnt_e last);
    case (last)
      GNT_CMD:  rr_next = GNT_TICK;
      GNT_TICK: rr_next = GNT_RND;
      default:  rr_next = GNT_CMD;
    endcase
  endfunction

endpackage

// File: rtl/stat_access_arbiter_sat_add.sv
// Saturating add of an unsigned stat and a one-bit-wider signed delta, clamped to [0, 2^STAT_W-1].
// Latency: purely combinational.
// Backpressure: none.
module stat_sat_add #(
  parameter int STAT_W = 4
) (
  input  logic [STAT_W-1:0] stat_i,
  input  logic [STAT_W:0]   delta_i,
  output logic [STAT_W-1:0] sum_o
);

  // Two extra bits hold every possible sum; the top bit is the sign in two's complement
  logic [STAT_W+1:0] sum_full;

  // Widen both operands (delta sign-extended), add, then clamp on sign / overflow bit
  always_comb begin
    sum_full = {2'b00, stat_i} + {delta_i[STAT_W], delta_i};
    if (sum_full[STAT_W+1]) begin
      sum_o = '0;
    end else if (sum_full[STAT_W]) begin
      sum_o = '1;
    end else begin
      sum_o = sum_full[STAT_W-1:0];
    end
  end

endmodule

// File: rtl/stat_access_arbiter.sv
// Arbitrates cmd/tick/rnd requesters onto the single stat register-file port as atomic saturating RMWs.
// Latency: ready in the request cycle, write 2 cycles later; one update per 3 cycles.
// Backpressure: ready only in IDLE and only to the winner; losers hold valid. Optional macro STAT_ARB_RR_EN.
module stat_access_arbiter
  import stat_access_arbiter_pkg::*;
#(
  parameter int NUM_STATS    = 6,
  parameter int STAT_W       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [STAT_W:0]  cmd_delta,
  input  logic             tick_valid,
  output logic             tick_ready,
  input  logic [SEL_W-1:0] tick_sel,
  input  logic [STAT_W:0]  tick_delta,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  input  logic [SEL_W-1:0] rnd_sel,
  input  logic [STAT_W:0]  rnd_delta,
  output logic [SEL_W-1:0] rf_rd_addr,
  input  logic [STAT_W-1:0] rf_rd_data,
  output logic             rf_wr_en,
  output logic [SEL_W-1:0] rf_wr_addr,
  output logic [STAT_W-1:0] rf_wr_data,
  output logic             busy,
  output logic [1:0]       grant_id,
  output logic             err_sel
);

  localparam logic [SEL_W-1:0] SEL_LIMIT = SEL_W'(NUM_STATS);

  state_e            state_q, state_d;
  gnt_e              win, gnt_q;
  logic              win_ok;
  logic [SEL_W-1:0]  win_sel, sel_q;
  logic [STAT_W:0]   win_delta, delta_q;
  logic [STAT_W-1:0] sum, wr_data_q;
  logic              busy_q, err_q;

`ifdef STAT_ARB_RR_EN
  gnt_e rr_ptr_q;

  // Round-robin pick starting at the pointer; nobody wins outside IDLE or during reset
  always_comb begin
    win = GNT_NONE;
    if (state_q == ST_IDLE && !reset) begin
      case (rr_ptr_q)
        GNT_TICK: begin
          if (tick_valid)     win = GNT_TICK;
          else if (rnd_valid) win = GNT_RND;
          else if (cmd_valid) win = GNT_CMD;
        end
        GNT_RND: begin
          if (rnd_valid)       win = GNT_RND;
          else if (cmd_valid)  win = GNT_CMD;
          else if (tick_valid) win = GNT_TICK;
        end
        default: begin
          if (cmd_valid)       win = GNT_CMD;
          else if (tick_valid) win = GNT_TICK;
          else if (rnd_valid)  win = GNT_RND;
        end
      endcase
    end
  end

  // Pointer moves to the requester after each winner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= GNT_CMD;
    end else if (win != GNT_NONE) begin
      rr_ptr_q <= rr_next(win);
    end
  end
`else
  localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  // Fixed priority cmd > rnd > tick, except a starved tick jumps the queue
  always_comb begin
    win = GNT_NONE;
    if (state_q == ST_IDLE && !reset) begin
      if (tick_valid && starve_q == STARVE_MAX) win = GNT_TICK;
      else if (cmd_valid)                       win = GNT_CMD;
      else if (rnd_valid)                       win = GNT_RND;
      else if (tick_valid)                      win = GNT_TICK;
    end
  end

  // Count arbitrations tick lost while waiting; clear whenever tick wins
  always_comb begin
    starve_d = starve_q;
    if (win == GNT_TICK) begin
      starve_d = '0;
    end else if (win != GNT_NONE && tick_valid && starve_q != STARVE_MAX) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`endif

  // Route the winner's target and delta to the capture registers
  always_comb begin
    win_sel   = '0;
    win_delta = '0;
    case (win)
      GNT_CMD:  begin win_sel = cmd_sel;  win_delta = cmd_delta;  end
      GNT_TICK: begin win_sel = tick_sel; win_delta = tick_delta; end
      GNT_RND:  begin win_sel = rnd_sel;  win_delta = rnd_delta;  end
      default:  ;
    endcase
  end

  assign win_ok = (win_sel < SEL_LIMIT);

  stat_sat_add #(.STAT_W(STAT_W)) u_sat_add (
    .stat_i  (rf_rd_data),
    .delta_i (delta_q),
    .sum_o   (sum)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: a bad sel is handshaked but never leaves IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (win != GNT_NONE && win_ok) state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake in IDLE, read port in READ, single write strobe in WRITE
  always_comb begin
    cmd_ready  = (win == GNT_CMD);
    tick_ready = (win == GNT_TICK);
    rnd_ready  = (win == GNT_RND);
    rf_rd_addr = '0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    case (state_q)
      ST_READ:  rf_rd_addr = sel_q;
      ST_WRITE: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = sel_q;
        rf_wr_data = wr_data_q;
      end
      default:  ;
    endcase
  end

  // Capture the granted request, the clamped sum during READ, and the sel-error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q     <= '0;
      delta_q   <= '0;
      gnt_q     <= GNT_NONE;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_data_q <= '0;
    end else begin
      err_q <= (win != GNT_NONE) && !win_ok;
      case (state_q)
        ST_IDLE: begin
          if (win != GNT_NONE && win_ok) begin
            sel_q   <= win_sel;
            delta_q <= win_delta;
            gnt_q   <= win;
            busy_q  <= 1'b1;
          end
        end
        ST_READ:  wr_data_q <= sum;
        ST_WRITE: begin
          busy_q <= 1'b0;
          gnt_q  <= GNT_NONE;
        end
        default:  ;
      endcase
    end
  end

  assign busy     = busy_q;
  assign grant_id = gnt_q;
  assign err_sel  = err_q;

endmodule
